phase_controller: RTL
=====================

# phase_controller

Eight-phase instruction sequencer for the VeriRisc CPU. It steps a 3-bit phase counter once per enabled clock and decodes phase, opcode and the accumulator zero flag into the memory, address-mux and register-load strobes. Those strobes drive the instruction register, accumulator and program counter `load` inputs, plus the memory `rd`/`wr` and the data bus driver. It also holds the sticky halt state and a retired-instruction counter.

## Interface
- `CNT_WIDTH`, default 16: width of the retired-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  advance the sequencer; when low, the phase holds.
- `opcode`  in  3  opcode from the instruction register output. Encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero`  in  1  accumulator-is-zero flag.
- `phase`  out  3  current phase, 0..7.
- `sel`  out  1  address mux: 1 selects the PC, 0 selects the IR address field.
- `rd`  out  1  memory read enable.
- `wr`  out  1  memory write strobe.
- `ld_ir`  out  1  instruction register load.
- `ld_ac`  out  1  accumulator load.
- `ld_pc`  out  1  program counter load (jump).
- `inc_pc`  out  1  program counter increment.
- `data_e`  out  1  drive the accumulator onto the data bus.
- `halt`  out  1  processor halted.
- `instr_count`  out  CNT_WIDTH  number of completed instructions.

## Operation
- **Phase names:** 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- **Phase advance:** with `enable`=1 and not halted, `phase` increments by 1 each clock and wraps 7 -> 0.
- **ALUOP** is defined as opcode ∈ {ADD, AND, XOR, LDA}.
- **Output decode** is combinational from the `phase` register, `opcode` and `zero`. Any signal not listed for a phase is 0.
  - `sel` = 1 in phases 0–3.
  - `rd` = 1 in phases 1–3; `rd` = ALUOP in phases 5–7.
  - `ld_ir` = 1 in phases 2–3.
  - In phase 4: `inc_pc` = 1, and `halt` = (opcode==HLT).
  - In phase 6: `inc_pc` = (opcode==SKZ && zero).
  - In phases 6–7: `ld_pc` = (opcode==JMP), and `data_e` = (opcode==STO).
  - In phase 7: `ld_ac` = ALUOP, and `wr` = (opcode==STO).
- **Gating when `enable`=0:** the strobes `ld_ir`, `ld_ac`, `ld_pc`, `inc_pc` and `wr` are forced to 0. `sel`, `rd`, `data_e` and `halt` keep their decoded values.
- **Halt:**
  - In phase 4 with opcode HLT and `enable`=1, the internal `halted` flag sets on the clock edge.
  - While halted: `phase` is frozen at 4, `halt`=1, and every other strobe, including `sel`, `rd` and `inc_pc`, is 0.
  - `instr_count` is frozen while halted.
  - Only `rst` clears the halt state.
  - `inc_pc` is also 0 in the phase-4 cycle that detects HLT, so the PC points at the HLT instruction.
- **Retired-instruction counter:** `instr_count` increments on each enabled 7 -> 0 transition and wraps modulo 2^CNT_WIDTH. HLT never retires.

## Timing
- **Reset:** `phase`=0, `halted`=0, `instr_count`=0. Resulting outputs: `sel`=1, all others 0.
- **Cycle cost:** one instruction takes 8 enabled clocks.
- **Strobe alignment:** register loads take effect on the edge that ends the phase in which the load strobe is high. For example, the IR captures at the end of phase 2 and again at the end of phase 3, with the same data both times.
- **`opcode` stability:** `opcode` must be stable from phase 3 through phase 7. The controller does not register it.
- **Reset mid-instruction:** any phase, including halted, returns to phase 0 on the next edge. `instr_count` clears. No strobe other than the phase-0 decode is asserted in the cycle after reset.
- **`enable` low mid-instruction:** the phase holds indefinitely. The instruction resumes at the same phase when `enable` returns high, with no extra cycles.
- **`rst` and `enable` high together:** `rst` wins.

## Test plan
- **Reset and free run:** `rst`=1 then release, `enable`=1, opcode=ADD → `phase` goes 0,1,…,7,0. `ld_ac`=1 only in phase 7. `rd`=1 in phases 1,2,3,5,6,7. `instr_count`=1 after 8 clocks.
- **STO:** opcode=6 → `data_e`=1 in phases 6–7, `wr`=1 only in phase 7, `rd`=0 in phases 5–7.
- **SKZ with `zero`:** `zero`=1 → `inc_pc`=1 in phases 4 and 6. With `zero`=0 → `inc_pc`=1 only in phase 4.
- **JMP:** `ld_pc`=1 in phases 6–7, `inc_pc`=1 in phase 4, `ld_ac`=0.
- **HLT:** after reaching phase 4 → `halt`=1 and `inc_pc`=0. `phase` stays at 4 for 20 clocks with all other strobes 0 and `instr_count` unchanged. `rst` → `phase`=0, `halt`=0.
- **`enable` gating and wrap:** drop `enable` in phase 7 for 5 clocks → `phase` stays 7 and `ld_ac`=0 throughout. When `enable` is restored, `ld_ac`=1 for one cycle, then phase 0. With CNT_WIDTH=4, after 16 instructions `instr_count` wraps to 0.

Source files
------------

// File: rtl/phase_controller.sv
`default_nettype none
// ============================================================================
//  Module   : phase_controller
//  Purpose  : Eight-phase VeriRisc instruction sequencer with sticky halt and
//             a retired-instruction counter.
//  Revision : 1.0 - initial release
// ============================================================================
module phase_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [2:0]           opcode,
    input  logic                 zero,
    output logic [2:0]           phase,
    output logic                 sel,
    output logic                 rd,
    output logic                 wr,
    output logic                 ld_ir,
    output logic                 ld_ac,
    output logic                 ld_pc,
    output logic                 inc_pc,
    output logic                 data_e,
    output logic                 halt,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [2:0] c_OP_HLT = 3'd0;
    localparam logic [2:0] c_OP_SKZ = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_AND = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_LDA = 3'd5;
    localparam logic [2:0] c_OP_STO = 3'd6;
    localparam logic [2:0] c_OP_JMP = 3'd7;

    localparam logic [2:0] c_PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] c_PH_INST_FETCH = 3'd1;
    localparam logic [2:0] c_PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] c_PH_IDLE       = 3'd3;
    localparam logic [2:0] c_PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] c_PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] c_PH_ALU_OP     = 3'd6;
    localparam logic [2:0] c_PH_STORE      = 3'd7;

    logic [2:0]           r_phase;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_instr_count;

    logic w_aluop;
    logic w_hlt;
    logic w_advance;

    assign w_aluop   = (opcode == c_OP_ADD) || (opcode == c_OP_AND) ||
                       (opcode == c_OP_XOR) || (opcode == c_OP_LDA);
    assign w_hlt     = (opcode == c_OP_HLT);
    assign w_advance = enable && !r_halted;

    // Detecting HLT in OP_ADDR parks the phase there instead of advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase       <= c_PH_INST_ADDR;
            r_halted      <= 1'b0;
            r_instr_count <= '0;
        end else if (w_advance) begin
            if ((r_phase == c_PH_OP_ADDR) && w_hlt) begin
                r_halted <= 1'b1;
            end else begin
                r_phase <= r_phase + 3'd1;
                if (r_phase == c_PH_STORE) begin
                    r_instr_count <= r_instr_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;

        case (r_phase)
            c_PH_INST_ADDR: begin
                sel = 1'b1;
            end
            c_PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            c_PH_INST_LOAD, c_PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            c_PH_OP_ADDR: begin
                // PC is left pointing at a HLT so a restart re-fetches it.
                inc_pc = !w_hlt;
                halt   = w_hlt;
            end
            c_PH_OP_FETCH: begin
                rd = w_aluop;
            end
            c_PH_ALU_OP: begin
                rd     = w_aluop;
                inc_pc = (opcode == c_OP_SKZ) && zero;
                ld_pc  = (opcode == c_OP_JMP);
                data_e = (opcode == c_OP_STO);
            end
            c_PH_STORE: begin
                rd     = w_aluop;
                ld_pc  = (opcode == c_OP_JMP);
                data_e = (opcode == c_OP_STO);
                ld_ac  = w_aluop;
                wr     = (opcode == c_OP_STO);
            end
            default: begin
                sel = 1'b0;
            end
        endcase

        if (!enable) begin
            ld_ir  = 1'b0;
            ld_ac  = 1'b0;
            ld_pc  = 1'b0;
            inc_pc = 1'b0;
            wr     = 1'b0;
        end

        if (r_halted) begin
            sel    = 1'b0;
            rd     = 1'b0;
            wr     = 1'b0;
            ld_ir  = 1'b0;
            ld_ac  = 1'b0;
            ld_pc  = 1'b0;
            inc_pc = 1'b0;
            data_e = 1'b0;
            halt   = 1'b1;
        end
    end

    assign phase       = r_phase;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire
